hdmi_pattern_gen: RTL and testbench
===================================

# hdmi_pattern_gen

Parametrised video timing and test-pattern generator for the HDMI path. It produces one pixel per `pixclk` cycle: 8-bit-class RGB plus hsync, vsync and data-enable. It replaces the free-running RGB counter in the HDMI bring-up top level and feeds `HDMI_Transciever` directly. It adds full CEA-style blanking and sync timing, selectable patterns, and per-frame animation.

## Interface
Parameters:
- `H_ACTIVE`, 640: active pixels per line; must be a multiple of 8.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: active lines.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `SYNC_ACT`, 0: asserted level of hsync and vsync (0 = active-low).
- `COLOR_W`, 8: bits per colour channel; must be 4 to 12.

Ports:
- `pixclk` in 1: pixel clock. Everything is synchronous to its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mode` in 2: pattern select. 0 = ramp, 1 = colour bars, 2 = checkerboard, 3 = animated.
- `red`, `green`, `blue` out COLOR_W each: pixel colour; all zero whenever `de`=0.
- `hsync` out 1: horizontal sync, polarity set by `SYNC_ACT`.
- `vsync` out 1: vertical sync, polarity set by `SYNC_ACT`.
- `de` out 1: active-video flag.
- `frame_start` out 1: one-cycle pulse coincident with pixel (0,0).
- `x` out 12: horizontal position of the current output pixel.
- `y` out 11: vertical position of the current output pixel.

## Operation
- Counters and localparams:
  - `H_TOTAL` = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - `V_TOTAL` = V_ACTIVE+V_FP+V_SYNC+V_BP.
  - `h` counts 0..H_TOTAL-1 and wraps to 0.
  - `v` increments when `h` wraps and itself wraps to 0 after V_TOTAL-1.
- Region decode:
  - `de` = (h<H_ACTIVE) and (v<V_ACTIVE).
  - hsync is asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync is asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for every h of those lines.
- `x`=h and `y`=v, registered alongside the other outputs.
- Frame state:
  - `mode_q` latches `mode` when h=0 and v=0. A change mid-frame takes effect from the next frame's pixel (0,0).
  - `frame_cnt` (8 bit) increments at h=H_TOTAL-1, v=V_TOTAL-1 and wraps 255→0.
- Patterns, where F = all ones (2^COLOR_W-1):
  - Ramp: all three channels = x mod 2^COLOR_W.
  - Colour bars: 8 bars of width BAR_W=H_ACTIVE/8, in order white, yellow, cyan, green, magenta, red, blue, black. Each channel is F or 0.
  - Colour bars are generated by a bar-index counter that resets at h=0 and advances every BAR_W pixels. No divider.
  - Checkerboard: all channels = F if x[5]^y[5], else 0 (32×32 squares).
  - Animated: red=(x+frame_cnt) mod 2^COLOR_W; green=y mod 2^COLOR_W; blue=frame_cnt truncated or zero-extended to COLOR_W.
- Outside `de`: RGB=0.

## Timing
- Latency: one register stage. Counter state (h,v) during cycle n appears on all outputs after the rising edge that ends cycle n. All outputs share that stage, so sync, de, x, y and RGB are mutually aligned.
- Reset values (any edge with `rst`=1):
  - h, v and frame_cnt are 0; mode_q is 0.
  - `de`, `frame_start` and RGB are 0; x and y are 0.
  - hsync and vsync are at the inactive level (~SYNC_ACT).
- First edge with `rst`=0: outputs show pixel (0,0) with `de`=1 and `frame_start`=1, and mode is sampled then.
- Reset asserted mid-frame: at the next edge, state returns to the reset values regardless of position. No partial line completes.
- Frame period is H_TOTAL×V_TOTAL cycles, measured between `frame_start` pulses.

## Test plan
- Reset: hold `rst` 5 cycles with defaults → `de`=0, hsync=vsync=1, RGB=0. On the first edge after release: `de`=1, `frame_start`=1, x=0, y=0.
- Line timing with defaults → per 800-cycle line:
  - `de` high for 640 cycles.
  - hsync low for exactly x=656..751.
  - vsync low on lines 490–491 only.
  - `frame_start` period 420000 cycles.
- Colour bars (mode=1) → x=0: (255,255,255); x=80: (255,255,0); x=400: (255,0,0); x=639: (0,0,0); x=640: (0,0,0) with de=0.
- Checkerboard and ramp, with small parameters (H_ACTIVE=64, V_ACTIVE=64, porches 2) → mode 2: (31,0)=0, (32,0)=F, (32,32)=0. Mode 0: pixel x=37 gives all channels 37.
- Mode switch mid-frame, 0→3 at y=100 → frame continues as ramp until the next `frame_start`. Then red at x=10 is 10+frame_cnt. frame_cnt wraps 255→0 over 256 frames.
- Reset asserted at (h=300, v=200) for one cycle → outputs take reset values the next edge. The following edge shows (0,0) with `frame_start`=1.

Source files
------------

// File: rtl/hdmi_pattern_gen.sv
// hdmi_pattern_gen: video timing and test-pattern generator, one pixel per pixclk
// Ports:
//   pixclk             pixel clock, all logic on its rising edge
//   rst                synchronous active-high reset
//   mode[1:0]          pattern: 0 ramp, 1 colour bars, 2 checkerboard, 3 animated
//   red/green/blue     pixel colour, zero outside active video
//   hsync/vsync        sync pulses, asserted level SYNC_ACT
//   de                 active-video flag
//   frame_start        one-cycle pulse on pixel (0,0)
//   x[11:0]/y[10:0]    position of the pixel currently on the outputs
module hdmi_pattern_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_ACT = 1'b0,
    parameter int   COLOR_W  = 8
) (
    input  logic               pixclk,
    input  logic               rst,
    input  logic [1:0]         mode,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               frame_start,
    output logic [11:0]        x,
    output logic [10:0]        y
);
    localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);
    localparam logic [COLOR_W-1:0] F = {COLOR_W{1'b1}};

    logic [11:0]        h, bar_px;
    logic [10:0]        v;
    logic [7:0]         frame_cnt;
    logic [2:0]         bar_idx;
    logic [1:0]         mode_q, mode_eff;
    logic               first, act;
    logic [COLOR_W-1:0] fc, chk, r_n, g_n, b_n;

    // Pixel (0,0) uses the live mode input so a new mode lands exactly on the frame boundary.
    always_comb begin
        first    = h == 12'd0 && v == 11'd0;
        mode_eff = first ? mode : mode_q;
        act      = h < H_ACT && v < V_ACT;
        fc       = COLOR_W'(frame_cnt);
        chk      = (h[5] ^ v[5]) ? F : '0;
        r_n = mode_eff == 2'd0 ? COLOR_W'(h) : mode_eff == 2'd1 ? (bar_idx[1] ? '0 : F) :
              mode_eff == 2'd2 ? chk : COLOR_W'(h) + fc;
        g_n = mode_eff == 2'd0 ? COLOR_W'(h) : mode_eff == 2'd1 ? (bar_idx[2] ? '0 : F) :
              mode_eff == 2'd2 ? chk : COLOR_W'(v);
        b_n = mode_eff == 2'd0 ? COLOR_W'(h) : mode_eff == 2'd1 ? (bar_idx[0] ? '0 : F) :
              mode_eff == 2'd2 ? chk : fc;
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            h           <= '0;
            v           <= '0;
            frame_cnt   <= '0;
            mode_q      <= '0;
            bar_px      <= '0;
            bar_idx     <= '0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            hsync       <= ~SYNC_ACT;
            vsync       <= ~SYNC_ACT;
            de          <= 1'b0;
            frame_start <= 1'b0;
            x           <= '0;
            y           <= '0;
        end else begin
            h <= h == H_LAST ? 12'd0 : h + 12'd1;
            if (h == H_LAST)
                v <= v == V_LAST ? 11'd0 : v + 11'd1;
            if (h == H_LAST && v == V_LAST)
                frame_cnt <= frame_cnt + 8'd1;
            if (first)
                mode_q <= mode;
            // Bar index tracks h/BAR_W incrementally; it free-runs through blanking where de masks it.
            if (h == H_LAST) begin
                bar_px  <= '0;
                bar_idx <= '0;
            end else if (bar_px == BAR_LAST) begin
                bar_px  <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_px <= bar_px + 12'd1;
            end
            red         <= act ? r_n : '0;
            green       <= act ? g_n : '0;
            blue        <= act ? b_n : '0;
            hsync       <= (h >= HS_BEG && h < HS_END) ? SYNC_ACT : ~SYNC_ACT;
            vsync       <= (v >= VS_BEG && v < VS_END) ? SYNC_ACT : ~SYNC_ACT;
            de          <= act;
            frame_start <= first;
            x           <= h;
            y           <= v;
        end
    end
endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// tb_hdmi_pattern_gen: directed checks of timing, patterns, mode latching, reset and frame counter
`timescale 1ns/1ps
module tb_hdmi_pattern_gen;
    logic pixclk = 1'b0;
    logic rst = 1'b1, rst_c = 1'b1;
    logic [1:0] mode_a = 2'd0, mode_b = 2'd0, mode_c = 2'd3;

    logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
    logic        hs_a, vs_a, de_a, fs_a, hs_b, vs_b, de_b, fs_b, hs_c, vs_c, de_c, fs_c;
    logic [11:0] x_a, x_b, x_c;
    logic [10:0] y_a, y_b, y_c;

    int checks = 0, errors = 0;

    always #5 pixclk = ~pixclk;

    // A: default horizontal timing, short vertical timing (15 lines, 12000-cycle frame)
    hdmi_pattern_gen #(.V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)) dut_a (
        .pixclk(pixclk), .rst(rst), .mode(mode_a), .red(r_a), .green(g_a), .blue(b_a),
        .hsync(hs_a), .vsync(vs_a), .de(de_a), .frame_start(fs_a), .x(x_a), .y(y_a));

    // B: 64x64 active, porches/sync of 2 (70x70 total)
    hdmi_pattern_gen #(.H_ACTIVE(64), .H_FP(2), .H_SYNC(2), .H_BP(2),
                       .V_ACTIVE(64), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut_b (
        .pixclk(pixclk), .rst(rst), .mode(mode_b), .red(r_b), .green(g_b), .blue(b_b),
        .hsync(hs_b), .vsync(vs_b), .de(de_b), .frame_start(fs_b), .x(x_b), .y(y_b));

    // C: tiny 11x5 frame (55 cycles) for the 256-frame counter wrap
    hdmi_pattern_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
                       .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)) dut_c (
        .pixclk(pixclk), .rst(rst_c), .mode(mode_c), .red(r_c), .green(g_c), .blue(b_c),
        .hsync(hs_c), .vsync(vs_c), .de(de_c), .frame_start(fs_c), .x(x_c), .y(y_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int de_line = 0, hs_cnt = 0, hs_first = -1, hs_last = -1;
        int de_frame = 0, vs_cnt = 0, vs_first = -1, vs_last = -1, fs_cnt = 0, pos_bad = 0;
        int per_bad = 0, n;

        repeat (5) @(negedge pixclk);
        check("rst_de", de_a, 0);
        check("rst_hsync", hs_a, 1);
        check("rst_vsync", vs_a, 1);
        check("rst_rgb", {r_a, g_a, b_a}, 0);
        check("rst_fs", fs_a, 0);
        check("rst_xy", {x_a, 1'b0, y_a}, 0);

        rst = 1'b0;
        mode_a = 2'd1;
        mode_b = 2'd2;
        @(negedge pixclk);
        check("rel_de", de_a, 1);
        check("rel_fs", fs_a, 1);
        check("rel_xy", {x_a, 1'b0, y_a}, 0);

        for (int i = 0; i < 16300; i++) begin
            if (i < 800) begin
                if (de_a) de_line++;
                if (!hs_a) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = i;
                    hs_last = i;
                end
            end
            if (i < 12000) begin
                if (de_a) de_frame++;
                if (fs_a) fs_cnt++;
                if (!vs_a) begin
                    vs_cnt++;
                    if (vs_first < 0) vs_first = i;
                    vs_last = i;
                end
                if (int'(x_a) != i % 800 || int'(y_a) != i / 800) pos_bad++;
            end
            case (i)
                0:     check("bar_x0", {r_a, g_a, b_a}, 24'hFFFFFF);
                31:    check("chk_31_0", {r_b, g_b, b_b}, 24'h000000);
                32:    check("chk_32_0", {r_b, g_b, b_b}, 24'hFFFFFF);
                80:    check("bar_x80", {r_a, g_a, b_a}, 24'hFFFF00);
                400:   check("bar_x400", {r_a, g_a, b_a}, 24'hFF0000);
                639: begin
                    check("bar_x639", {r_a, g_a, b_a}, 24'h000000);
                    check("de_x639", de_a, 1);
                end
                640: begin
                    check("bar_x640", {r_a, g_a, b_a}, 24'h000000);
                    check("de_x640", de_a, 0);
                end
                2272:  check("chk_32_32", {r_b, g_b, b_b}, 24'h000000);
                4810:  check("mode_hold", {r_a, g_a, b_a}, 24'hFFFFFF);
                4937:  check("ramp_x37", {r_b, g_b, b_b}, 24'h252525);
                12000: check("fs_period", fs_a, 1);
                12010: check("anim_x10", {r_a, g_a, b_a}, 24'h0B0001);
                default: ;
            endcase
            if (i == 100) mode_b = 2'd0;
            if (i == 4000) mode_a = 2'd3;
            if (i == 16299) rst = 1'b1;
            @(negedge pixclk);
        end

        check("de_line", de_line, 640);
        check("hs_cnt", hs_cnt, 96);
        check("hs_first", hs_first, 656);
        check("hs_last", hs_last, 751);
        check("de_frame", de_frame, 5120);
        check("vs_cnt", vs_cnt, 1600);
        check("vs_first", vs_first, 8000);
        check("vs_last", vs_last, 9599);
        check("fs_cnt", fs_cnt, 1);
        check("pos_bad", pos_bad, 0);

        check("mid_rst_de", de_a, 0);
        check("mid_rst_sync", {hs_a, vs_a}, 2'b11);
        check("mid_rst_xy", {x_a, 1'b0, y_a}, 0);
        check("mid_rst_rgb", {r_a, g_a, b_a}, 0);
        check("mid_rst_fs", fs_a, 0);
        rst = 1'b0;
        @(negedge pixclk);
        check("post_rst_fs", fs_a, 1);
        check("post_rst_de", de_a, 1);
        check("post_rst_xy", {x_a, 1'b0, y_a}, 0);
        repeat (10) @(negedge pixclk);
        check("post_rst_anim", {r_a, g_a, b_a}, 24'h0A0000);

        rst_c = 1'b0;
        @(negedge pixclk);
        check("c_fs0", fs_c, 1);
        check("c_blue0", b_c, 0);
        for (int f = 1; f <= 256; f++) begin
            n = 0;
            do begin
                @(negedge pixclk);
                n++;
            end while (!fs_c && n < 100);
            if (n != 55) per_bad++;
            if (f == 1) check("c_blue1", b_c, 8'd1);
            if (f == 255) check("c_blue255", {r_c, b_c}, 16'hFFFF);
            if (f == 256) check("c_wrap", {r_c, b_c}, 16'h0000);
        end
        check("c_period", per_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
